// File: rtl/mic_serial_capture_pkg.sv
// Shared types and constants for the mic serial capture path.
// Contents:
//   SAMPLE_W       default sample word width (bits per ADC frame)
//   MIC_SCLK_IDLE  level of sclk whenever no frame is being clocked
//   mic_state_e    capture FSM state encoding
//   sat_inc8       8-bit saturating increment used by the drop counter
package mic_serial_capture_pkg;

    localparam int   SAMPLE_W      = 16;
    localparam logic MIC_SCLK_IDLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        SHIFT = 2'd2,
        PUSH  = 2'd3
    } mic_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mic_serial_capture_if.sv
// Sample stream between the capture stage and the downstream memory writer.
// Signals:
//   data   sample word at the head of the capture FIFO
//   valid  head word present
//   ready  consumer takes the head word when valid & ready
// Modports: master = capture side (drives data/valid), slave = consumer side.
interface mic_serial_capture_if
    import mic_serial_capture_pkg::*;
#(
    parameter int W = SAMPLE_W
) ();

    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/mic_serial_capture_sync_fifo.sv
// First-word-fall-through synchronous FIFO for captured sample words.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears pointers, level and storage)
//   wr_en, wr_data    write request; accepted when not full, or when full and a pop
//                     happens in the same cycle
//   rd_en             pop request; ignored while empty
//   rd_data           head word, valid the cycle after it was written
//   empty, full       occupancy flags derived from level
//   level             exact occupancy, 0..DEPTH
module mic_serial_capture_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // A write into a full FIFO still succeeds when the head leaves in the same cycle.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));

endmodule

// File: rtl/mic_serial_capture.sv
// Serial mic ADC capture: generates sclk/ncs, shifts sdata in MSB-first on sclk
// rising edges, and queues each completed word in a FWFT FIFO presented on a
// valid/ready stream.
// Ports:
//   clk, rst       clock, synchronous active-high reset (aborts any frame in flight)
//   en             capture enable level; a frame in SHIFT always runs to completion
//   sclk, ncs      ADC serial clock (idles high) and active-low chip select, registered
//   sdata          ADC serial data
//   sample_if      master side of the sample stream (data/valid out, ready in)
//   fifo_level     current FIFO occupancy
//   overflow_cnt   words dropped because the FIFO was full, saturating at 255
//   busy           FSM not idle, registered
//
// state | meaning
// IDLE  | ncs=1, sclk=1, waiting for en
// GAP   | ncs=1, holds chip select inactive for GAP_CYCLES between frames
// SHIFT | ncs=0, clocks FRAME_BITS sclk periods, samples sdata on each rising edge
// PUSH  | ncs=1, one cycle, hands the word to the FIFO or counts a drop
module mic_serial_capture
    import mic_serial_capture_pkg::*;
#(
    parameter  int SCLK_HALF  = 16,
    parameter  int FRAME_BITS = SAMPLE_W,
    parameter  int GAP_CYCLES = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  sclk,
    output logic                  ncs,
    input  logic                  sdata,
    mic_serial_capture_if.master  sample_if,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [7:0]            overflow_cnt,
    output logic                  busy
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int DIV_W = $clog2(SCLK_HALF);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);

    mic_state_e             state;
    mic_state_e             state_next;
    logic [GAP_W-1:0]       gap_cnt;
    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [FRAME_BITS-1:0]  shreg;

    logic                   sclk_next;
    logic                   ncs_next;
    logic                   gap_load;
    logic                   div_load;
    logic                   sample_en;
    logic                   bit_clr;
    logic                   push_en;
    logic                   drop;

    logic                   fifo_empty;
    logic                   fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sclk  <= MIC_SCLK_IDLE;
            ncs   <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            sclk  <= sclk_next;
            ncs   <= ncs_next;
            busy  <= (state_next != IDLE);
        end
    end

    // div_cnt is a per-half-period down-counter; at terminal count the current
    // sclk level (the output flop itself) decides whether to rise, fall or finish.
    always_comb begin
        state_next = state;
        sclk_next  = MIC_SCLK_IDLE;
        ncs_next   = 1'b1;
        gap_load   = 1'b0;
        div_load   = 1'b0;
        sample_en  = 1'b0;
        bit_clr    = 1'b0;
        push_en    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = GAP;
                    gap_load   = 1'b1;
                end
            end
            GAP: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (gap_cnt == '0) begin
                    state_next = SHIFT;
                    ncs_next   = 1'b0;
                    sclk_next  = 1'b0;
                    div_load   = 1'b1;
                    bit_clr    = 1'b1;
                end
            end
            SHIFT: begin
                ncs_next  = 1'b0;
                sclk_next = sclk;
                if (div_cnt == '0) begin
                    if (!sclk) begin
                        sclk_next = 1'b1;
                        div_load  = 1'b1;
                        sample_en = 1'b1;
                    end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                        state_next = PUSH;
                        ncs_next   = 1'b1;
                        sclk_next  = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        div_load  = 1'b1;
                    end
                end
            end
            PUSH: begin
                push_en = 1'b1;
                if (en) begin
                    state_next = GAP;
                    gap_load   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A full FIFO still accepts the word when the consumer pops in the same cycle.
    assign drop = push_en && fifo_full && !sample_if.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt      <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (gap_load) begin
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            if (div_load) begin
                div_cnt <= DIV_W'(SCLK_HALF - 1);
            end else if (state == SHIFT && div_cnt != '0) begin
                div_cnt <= div_cnt - DIV_W'(1);
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (sample_en) begin
                shreg <= {shreg[FRAME_BITS-2:0], sdata};
            end

            if (drop) begin
                overflow_cnt <= sat_inc8(overflow_cnt);
            end
        end
    end

    mic_serial_capture_sync_fifo #(
        .WIDTH (FRAME_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_en),
        .wr_data (shreg),
        .rd_en   (sample_if.ready),
        .rd_data (sample_if.data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign sample_if.valid = !fifo_empty;

endmodule

// File: tb/tb_mic_serial_capture.sv
// Bench for mic_serial_capture: an ADC model drives sdata off sclk falling edges,
// and a queue-based model of the sample FIFO tracks level, head word and drops.
module tb_mic_serial_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sdata = 1'b0;
    logic        ready = 1'b0;
    logic        sclk;
    logic        ncs;
    logic        busy;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    mic_serial_capture_if #(.W(16)) sif ();
    assign sif.ready = ready;

    mic_serial_capture dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sclk         (sclk),
        .ncs          (ncs),
        .sdata        (sdata),
        .sample_if    (sif),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    localparam int FRAME_LEN = 8 + 16 * 2 * 16 + 1;

    int n_vec  = 0;
    int n_miss = 0;

    // ADC model: a new word is chosen on the first sclk falling edge of a frame,
    // one bit per falling edge, MSB first.
    int          tx_idx = 0;
    int          tx_mode = 0;          // 0 fixed A5C3, 1 counting, 2 random
    logic [15:0] tx_seq = 16'd0;
    logic [15:0] tx_word = 16'd0;
    int          frames_done = 0;
    bit          pend = 1'b0;
    logic [15:0] pend_word = 16'd0;

    always @(negedge sclk) begin
        if (tx_idx == 0) begin
            case (tx_mode)
                0:       tx_word = 16'hA5C3;
                1:       begin tx_word = tx_seq; tx_seq = tx_seq + 16'd1; end
                default: tx_word = 16'($urandom);
            endcase
        end
        if (tx_idx < 16) begin
            sdata  = tx_word[15 - tx_idx];
            tx_idx = tx_idx + 1;
        end
    end

    // Chip select going inactive after all 16 bits means the frame reached PUSH.
    always @(posedge ncs) begin
        if (tx_idx == 16 && rst === 1'b0) begin
            pend        = 1'b1;
            pend_word   = tx_word;
            frames_done = frames_done + 1;
        end
        tx_idx = 0;
    end

    // FIFO reference model
    logic [15:0] mq[$];
    int          movf = 0;
    int          cyc = 0;
    int          last_fall = -1;
    bit          spacing_on = 1'b0;
    logic        ncs_prev = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the model for the coming edge, advance one clock, then check at negedge.
    task automatic tick();
        if (rst) begin
            mq.delete();
            movf = 0;
            pend = 1'b0;
        end else begin
            if (ready && mq.size() != 0) void'(mq.pop_front());
            if (pend) begin
                if (mq.size() < 8) mq.push_back(pend_word);
                else if (movf < 255) movf++;
                pend = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("valid", 32'(sif.valid), 32'(mq.size() != 0));
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("overflow_cnt", 32'(overflow_cnt), 32'(movf));
        if (mq.size() != 0) chk("head_word", 32'(sif.data), 32'(mq[0]));
        if (ncs_prev === 1'b1 && ncs === 1'b0) begin
            if (spacing_on && last_fall >= 0) chk("frame_spacing", 32'(cyc - last_fall), 32'(FRAME_LEN));
            last_fall = cyc;
        end
        ncs_prev = ncs;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("frame_wait", 32'(frames_done), 32'(target));
    endtask

    initial begin
        int n;
        int rises;
        int lows;
        int base;
        logic prev;
        logic [15:0] w;

        // Reset state
        repeat (3) tick();
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_ncs", 32'(ncs), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(sif.valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single A5C3 frame: gap, sclk shape, word and valid timing
        tx_mode = 0;
        en = 1'b1;
        tick();
        chk("busy_rise", 32'(busy), 32'd1);
        chk("ncs_in_gap", 32'(ncs), 32'd1);
        n = 0;
        while (ncs && n < 40) begin tick(); n++; end
        chk("ncs_fall_delay", 32'(n), 32'd8);
        chk("sclk_at_cs_fall", 32'(sclk), 32'd0);
        n = 0; rises = 0; lows = 0; prev = sclk;
        while (!ncs && n < 1000) begin
            tick();
            n++;
            if (!ncs && !sclk) lows++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        chk("cs_low_cycles", 32'(n), 32'd512);
        chk("sclk_rises", 32'(rises), 32'd16);
        chk("sclk_low_cycles", 32'(lows), 32'd255);
        chk("valid_in_push", 32'(sif.valid), 32'd0);
        tick();
        chk("valid_after_push", 32'(sif.valid), 32'd1);
        chk("word_a5c3", 32'(sif.data), 32'h0000A5C3);
        en = 1'b0;
        tick();
        chk("gap_abort_busy", 32'(busy), 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // Ten frames into an eight-deep FIFO with no consumer
        tx_mode = 1;
        tx_seq = 16'd0;
        base = frames_done;
        en = 1'b1;
        wait_frames(base + 10, 10 * FRAME_LEN + 600);
        en = 1'b0;
        tick();
        chk("fill_level", 32'(fifo_level), 32'd8);
        chk("fill_overflow", 32'(overflow_cnt), 32'd2);
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(sif.valid), 32'd1);
            chk("drain_order", 32'(sif.data), 32'(i));
            tick();
        end
        ready = 1'b0;
        chk("drain_empty", 32'(sif.valid), 32'd0);

        // Full FIFO with push and pop in the same cycle (words 10..18)
        base = frames_done;
        en = 1'b1;
        wait_frames(base + 9, 9 * FRAME_LEN + 600);
        chk("full_before", 32'(fifo_level), 32'd8);
        en = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("full_pushpop_level", 32'(fifo_level), 32'd8);
        chk("full_pushpop_ovf", 32'(overflow_cnt), 32'd2);
        chk("full_pushpop_head", 32'(sif.data), 32'd11);
        ready = 1'b1;
        repeat (8) tick();
        ready = 1'b0;
        chk("full_drained", 32'(fifo_level), 32'd0);

        // en dropped at bit 5: frame still completes, then the port idles
        tx_mode = 2;
        base = frames_done;
        en = 1'b1;
        n = 0;
        while (tx_idx < 5 && n < 2000) begin tick(); n++; end
        chk("reach_bit5", 32'(tx_idx), 32'd5);
        en = 1'b0;
        n = 0;
        while (!ncs && n < 1000) begin tick(); n++; end
        chk("late_stop_frame", 32'(frames_done), 32'(base + 1));
        w = tx_word;
        tick();
        chk("late_stop_level", 32'(fifo_level), 32'd1);
        chk("late_stop_word", 32'(sif.data), 32'(w));
        repeat (20) begin
            tick();
            chk("idle_ncs", 32'(ncs), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sclk", 32'(sclk), 32'd1);
        end

        // Reset at bit 9 with a word still queued and drops on record
        base = frames_done;
        en = 1'b1;
        n = 0;
        while (tx_idx < 9 && n < 2000) begin tick(); n++; end
        chk("reach_bit9", 32'(tx_idx), 32'd9);
        rst = 1'b1;
        tick();
        chk("midrst_sclk", 32'(sclk), 32'd1);
        chk("midrst_ncs", 32'(ncs), 32'd1);
        chk("midrst_valid", 32'(sif.valid), 32'd0);
        chk("midrst_level", 32'(fifo_level), 32'd0);
        chk("midrst_ovf", 32'(overflow_cnt), 32'd0);
        rst = 1'b0;
        wait_frames(base + 1, 2 * FRAME_LEN);
        w = tx_word;
        tick();
        chk("post_rst_level", 32'(fifo_level), 32'd1);
        chk("post_rst_word", 32'(sif.data), 32'(w));

        // Continuous random run with the consumer always ready
        ready = 1'b1;
        last_fall = -1;
        spacing_on = 1'b1;
        base = frames_done;
        wait_frames(base + 80, 81 * FRAME_LEN + 600);
        en = 1'b0;
        spacing_on = 1'b0;
        repeat (4) tick();
        chk("run_level", 32'(fifo_level), 32'd0);
        chk("run_overflow", 32'(overflow_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
